timer_clock_select: RTL
=======================

Name: timer_clock_select

Overview:
- Clock-source and external-reset front end for one 8-bit timer channel. Sits directly upstream of the channel counter.
- Runs a free-running prescaler and synchronises the TMCI/TMRI pins.
- Selects the count source from the TCR/TCCR clock-select fields.
- Emits one-cycle count_en and ext_clr strobes that the counter consumes.
- Single clock domain; the counter never uses a derived clock.

Parameters:
PRESCALE_WIDTH, 13, prescaler width; must cover divide-by-8192
SYNC_STAGES, 2, synchroniser flops on tmci and tmri (min 2)

Ports:
clk  input  1  system clock (Pφ)
reset_n  input  1  synchronous, active-high reset; 1 = reset
cks  input  3  clock select, from TCR CKS[2:0]
icks0  input  1  internal divider select, from TCCR ICKS0
tmci  input  1  external count clock pin, asynchronous
tmri  input  1  external counter-reset pin, asynchronous
cclr_ext_en  input  1  1 when TCR CCLR selects external reset
cascade_ovf  input  1  one-cycle overflow/match strobe from paired channel
count_en  output  1  one-cycle increment strobe to counter
ext_clr  output  1  one-cycle counter-clear strobe

Behaviour:
- Reset: applies on any clk edge with reset_n=1.
  - Prescaler P=0; all synchroniser and edge-history flops =0; arm counter =0.
  - count_en=0, ext_clr=0.
- Cycle numbering: cycle 0 is the first cycle after the last reset cycle.
- Prescaler:
  - P holds value c in cycle c and increments every cycle; wraps modulo 2^PRESCALE_WIDTH.
  - P is never cleared by cks/icks0 changes.
- Internal tick for divisor N (power of 2): P[log2(N)-1:0] == N-1.
- Source decode, evaluated every cycle from current cks/icks0:
  - cks=000: no source; count_en=0.
  - cks=001: N=8 (icks0=0) or N=2 (icks0=1).
  - cks=010: N=64 (icks0=0) or N=32 (icks0=1).
  - cks=011: N=8192 (icks0=0) or N=1024 (icks0=1).
  - cks=100: cascade; selected tick = cascade_ovf.
  - cks=101: tmci rising edge. cks=110: tmci falling edge. cks=111: tmci both edges.
- count_en is registered: high in cycle c+1 iff the selected tick is true in cycle c.
  - Internal mode from reset: count_en high in cycles N, 2N, 3N, ...
  - Cascade: one cycle latency.
- External synchronisation:
  - tmci and tmri each pass through SYNC_STAGES flops, then one history flop.
  - Edge = sync output vs history.
  - Latency from the first clk edge sampling the new pin level to strobe high = SYNC_STAGES+1 edges (3 by default).
- Minimum pin pulse: tmci/tmri high and low phases each ≥2 clk periods guarantee detection. Shorter pulses may be missed; no spurious multi-pulses.
- Arming after reset:
  - Edge detection is suppressed until the arm counter reaches SYNC_STAGES+1 (it saturates there).
  - A pin held high across reset release produces no strobe.
- Synchronisers and history flops run in all modes, so switching cks into an external mode never produces a strobe from stale history.
- ext_clr: registered; high one cycle on a synchronised tmri rising edge when cclr_ext_en=1 in the detecting cycle.
  - tmri held high produces a single pulse.
  - Falling edges are ignored.
- Simultaneous events:
  - count_en and ext_clr may both be high in one cycle. This block does not arbitrate; the counter gives clear priority.
  - A cks change takes effect on the next registered output. The old source's pending tick is not carried over.
- Reset mid-operation: outputs are 0 in the cycle after reset is sampled. The timing sequence restarts from cycle 0.

Test Plan:
1. cks=001, icks0=1 from reset -> count_en high cycles 2,4,6,... only. Switch to cks=011, icks0=0 at reset -> first pulse cycle 8192, next 16384.
2. cks=101, tmci square wave 4 low/4 high -> one count_en per rising edge, 3 cycles after sampling. cks=110 -> same on falling edges only.
3. cks=111, same tmci -> two count_en per period, each 3 cycles after the respective edge.
4. tmci=1 and cks=101 through reset release -> count_en stays 0. Then tmci low 3 cycles, high -> exactly one pulse.
5. tmri rising with cclr_ext_en=1 -> single ext_clr pulse 3 cycles later, with tmri held high 20 cycles. Repeat with cclr_ext_en=0 -> no pulse.
6. cks=100, cascade_ovf pulses at cycles 10 and 11 -> count_en at 11 and 12. Assert reset at cycle 50 during a /2 stream -> outputs 0 next cycle; pulses resume at cycles 2,4,... after release.

Source files
------------

// File: rtl/timer_clock_select_if.sv
// timer_clock_select_if
//   Groups the control, pin and strobe signals of one timer channel's
//   clock-source front end.
//   master : register/pin side (drives selects, pins, cascade strobe;
//            observes the strobes)
//   slave  : the front end itself (timer_clock_select)
//   Signals:
//     cks[2:0]     clock select from TCR CKS
//     icks0        internal divider select from TCCR ICKS0
//     tmci         external count clock pin (asynchronous)
//     tmri         external counter-reset pin (asynchronous)
//     cclr_ext_en  1 when TCR CCLR selects external reset
//     cascade_ovf  one-cycle overflow/match strobe from the paired channel
//     count_en     one-cycle increment strobe to the counter
//     ext_clr      one-cycle counter-clear strobe
interface timer_clock_select_if;
  logic [2:0] cks;
  logic       icks0;
  logic       tmci;
  logic       tmri;
  logic       cclr_ext_en;
  logic       cascade_ovf;
  logic       count_en;
  logic       ext_clr;

  modport master (
    output cks, icks0, tmci, tmri, cclr_ext_en, cascade_ovf,
    input  count_en, ext_clr
  );

  modport slave (
    input  cks, icks0, tmci, tmri, cclr_ext_en, cascade_ovf,
    output count_en, ext_clr
  );
endinterface

// File: rtl/timer_clock_select.sv
// timer_clock_select
//   Clock-source and external-reset front end for one 8-bit timer channel.
//   Runs a free-running prescaler, synchronises the TMCI/TMRI pins, picks
//   the count source from CKS/ICKS0 and emits registered one-cycle
//   count_en / ext_clr strobes for the downstream counter. Single clock
//   domain: the counter is always clocked by clk and only gated by count_en.
//   Ports:
//     clk      system clock
//     reset_n  synchronous reset, active HIGH despite the name (1 = reset)
//     bus      timer_clock_select_if.slave (selects, pins, strobes)
//   Parameters:
//     PRESCALE_WIDTH  prescaler width, at least 13 (divide-by-8192 tap)
//     SYNC_STAGES     synchroniser depth on tmci/tmri, at least 2
module timer_clock_select #(
  parameter int PRESCALE_WIDTH = 13,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  timer_clock_select_if.slave  bus
);

  // Edge detection opens once the synchronisers and history flop have all
  // been filled with real pin samples after reset.
  localparam int ARM_MAX = SYNC_STAGES + 1;
  localparam int ARM_W   = $clog2(ARM_MAX + 1);

  logic [PRESCALE_WIDTH-1:0] prescale;
  logic [SYNC_STAGES-1:0]    tmci_sync;
  logic [SYNC_STAGES-1:0]    tmri_sync;
  logic                      tmci_hist;
  logic                      tmri_hist;
  logic [ARM_W-1:0]          arm_cnt;

  logic armed;
  logic tmci_now;
  logic tmri_now;
  logic tmci_rise;
  logic tmci_fall;
  logic tmri_rise;
  logic sel_tick;

  assign armed    = (arm_cnt == ARM_W'(ARM_MAX));
  assign tmci_now = tmci_sync[SYNC_STAGES-1];
  assign tmri_now = tmri_sync[SYNC_STAGES-1];

  // Edges compare the synchroniser output against one extra history flop.
  assign tmci_rise = armed &  tmci_now & ~tmci_hist;
  assign tmci_fall = armed & ~tmci_now &  tmci_hist;
  assign tmri_rise = armed &  tmri_now & ~tmri_hist;

  // A divide-by-N tick fires when the low log2(N) prescaler bits are all
  // ones, i.e. on the last cycle of each N-cycle period. Because the
  // prescaler never stops, changing the divider does not restart its phase.
  always_comb begin
    sel_tick = 1'b0;
    case (bus.cks)
      3'b000: sel_tick = 1'b0;
      3'b001: sel_tick = bus.icks0 ? prescale[0]     : (&prescale[2:0]);
      3'b010: sel_tick = bus.icks0 ? (&prescale[4:0]) : (&prescale[5:0]);
      3'b011: sel_tick = bus.icks0 ? (&prescale[9:0]) : (&prescale[12:0]);
      3'b100: sel_tick = bus.cascade_ovf;
      3'b101: sel_tick = tmci_rise;
      3'b110: sel_tick = tmci_fall;
      3'b111: sel_tick = tmci_rise | tmci_fall;
      default: sel_tick = 1'b0;
    endcase
  end

  // Prescaler, synchronisers, history flops and arm counter all run in
  // every mode so that selecting an external source never sees stale
  // history. Strobes are registered one cycle after the selected tick.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      prescale     <= '0;
      tmci_sync    <= '0;
      tmri_sync    <= '0;
      tmci_hist    <= 1'b0;
      tmri_hist    <= 1'b0;
      arm_cnt      <= '0;
      bus.count_en <= 1'b0;
      bus.ext_clr  <= 1'b0;
    end else begin
      prescale     <= prescale + PRESCALE_WIDTH'(1);
      tmci_sync    <= {tmci_sync[SYNC_STAGES-2:0], bus.tmci};
      tmri_sync    <= {tmri_sync[SYNC_STAGES-2:0], bus.tmri};
      tmci_hist    <= tmci_now;
      tmri_hist    <= tmri_now;
      if (!armed) begin
        arm_cnt <= arm_cnt + ARM_W'(1);
      end
      bus.count_en <= sel_tick;
      bus.ext_clr  <= tmri_rise & bus.cclr_ext_en;
    end
  end

endmodule
